x_loop_seq: RTL

Counted-loop sequencer for the X pointer register of the SAP-2 mini datapath. It loads X from the 12-bit bus, then runs one handshaked step per count. Each step drives X onto the bus as an address, and X is decremented through its dex line until the iz flag reports zero. The block sits between the control unit and the X register and owns the lx/ex/inx/dex lines whenever it is busy.

---
 rtl/x_loop_seq_if.sv | 35 +++
 rtl/x_loop_seq.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/x_loop_seq_if.sv
// x_loop_seq_if: control and X-register lines for the X counted-loop sequencer.
//   slave  : view used by x_loop_seq (takes start/abort/step_ack/im/iz, drives the rest)
//   master : view used by the control unit / X register side
//   start, abort, step_ack : loop control and step handshake from the requester
//   im, iz                 : X minus / X zero flags from the X register
//   ld_req, lx, ex, inx, dex : bus source request and X register strobes
//   step_req, busy, done, err, abt, iter : loop status
interface x_loop_seq_if;
  logic        start;
  logic        abort;
  logic        step_ack;
  logic        im;
  logic        iz;
  logic        ld_req;
  logic        lx;
  logic        ex;
  logic        inx;
  logic        dex;
  logic        step_req;
  logic        busy;
  logic        done;
  logic        err;
  logic        abt;
  logic [11:0] iter;

  modport slave (
    input  start, abort, step_ack, im, iz,
    output ld_req, lx, ex, inx, dex, step_req, busy, done, err, abt, iter
  );

  modport master (
    output start, abort, step_ack, im, iz,
    input  ld_req, lx, ex, inx, dex, step_req, busy, done, err, abt, iter
  );
endinterface

// File: rtl/x_loop_seq.sv
// x_loop_seq: counted-loop sequencer for the X pointer register.
// Loads X from the bus, then issues one handshaked step per count, driving X
// onto the bus as the step address and decrementing X until iz reports zero.
//   clk   : system clock, rising edge
//   clr_n : asynchronous active-low reset
//   ctl   : x_loop_seq_if.slave (loop control, step handshake, X strobes, status)
//
// state | meaning
// IDLE  | waiting for start; abort_pend cleared
// LOAD  | lx + ld_req, X captures the count from the bus
// CHECK | decide: abort, negative count, zero reached, or another step
// STEP  | ex + step_req, X address on bus until step_ack or abort
// DEC   | dex, X decrements
// DONE  | one-cycle done pulse
module x_loop_seq (
  input  logic          clk,
  input  logic          clr_n,
  x_loop_seq_if.slave   ctl
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    CHECK = 3'd2,
    STEP  = 3'd3,
    DEC   = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t      state;
  logic        abort_pend;
  logic        ld_req_q;
  logic        lx_q;
  logic        ex_q;
  logic        dex_q;
  logic        step_req_q;
  logic        busy_q;
  logic        done_q;
  logic        err_q;
  logic        abt_q;
  logic [11:0] iter_q;

  // Outputs are registered together with the state so each one is a flop
  // output; the next-state branch sets the values that belong to the state
  // being entered.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state      <= IDLE;
      abort_pend <= 1'b0;
      ld_req_q   <= 1'b0;
      lx_q       <= 1'b0;
      ex_q       <= 1'b0;
      dex_q      <= 1'b0;
      step_req_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      abt_q      <= 1'b0;
      iter_q     <= 12'd0;
    end else begin
      case (state)
        IDLE: begin
          abort_pend <= 1'b0;
          if (ctl.start) begin
            state    <= LOAD;
            lx_q     <= 1'b1;
            ld_req_q <= 1'b1;
            busy_q   <= 1'b1;
            iter_q   <= 12'd0;
            err_q    <= 1'b0;
            abt_q    <= 1'b0;
          end
        end

        LOAD: begin
          if (ctl.abort) abort_pend <= 1'b1;
          lx_q     <= 1'b0;
          ld_req_q <= 1'b0;
          state    <= CHECK;
        end

        CHECK: begin
          if (abort_pend) begin
            state  <= DONE;
            abt_q  <= 1'b1;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end else if (ctl.im) begin
            // Only a loaded count with bit 11 set can get here; decrements
            // stop at zero so X never wraps negative.
            state  <= DONE;
            err_q  <= 1'b1;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end else if (ctl.iz) begin
            state  <= DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end else begin
            state      <= STEP;
            ex_q       <= 1'b1;
            step_req_q <= 1'b1;
          end
        end

        STEP: begin
          if (ctl.step_ack) begin
            // An acknowledged step always completes; a coincident abort is
            // deferred to the next CHECK.
            if (ctl.abort) abort_pend <= 1'b1;
            iter_q     <= iter_q + 12'd1;
            ex_q       <= 1'b0;
            step_req_q <= 1'b0;
            dex_q      <= 1'b1;
            state      <= DEC;
          end else if (ctl.abort) begin
            ex_q       <= 1'b0;
            step_req_q <= 1'b0;
            abt_q      <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            state      <= DONE;
          end
        end

        DEC: begin
          if (ctl.abort) abort_pend <= 1'b1;
          dex_q <= 1'b0;
          state <= CHECK;
        end

        DONE: begin
          done_q <= 1'b0;
          state  <= IDLE;
        end

        default: begin
          state      <= IDLE;
          ld_req_q   <= 1'b0;
          lx_q       <= 1'b0;
          ex_q       <= 1'b0;
          dex_q      <= 1'b0;
          step_req_q <= 1'b0;
          busy_q     <= 1'b0;
          done_q     <= 1'b0;
        end
      endcase
    end
  end

  assign ctl.ld_req   = ld_req_q;
  assign ctl.lx       = lx_q;
  assign ctl.ex       = ex_q;
  assign ctl.inx      = 1'b0;
  assign ctl.dex      = dex_q;
  assign ctl.step_req = step_req_q;
  assign ctl.busy     = busy_q;
  assign ctl.done     = done_q;
  assign ctl.err      = err_q;
  assign ctl.abt      = abt_q;
  assign ctl.iter     = iter_q;

endmodule
